// File: rtl/ierl78pucap7.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ierl78pucap7 : pull-up bus capture unit (IO-board side of the RL78 IECUBE
// 7-bank pull-up distribution bus).
//
// The time-multiplexed 30-bit PPUP bus and the seven PUPLE latch enables are
// synchronised, and each PUPLE rising edge latches PPUP into the bank it
// names. The block also checks bank ordering (0..6), illegal multi-hot
// enables and bus staleness. Any bank can be read back through BANKSEL.
//
// Parameters:
//   TMO_W     width of the stale watchdog counter (STALE after 2^TMO_W-1
//             cycles without a capture)
//
// Ports:
//   CLK60MHZ  in   system clock, posedge
//   CPURSOUT  in   asynchronous active-high reset
//   PPUP      in   30-bit pull-up data bus
//   PUPLE     in   7 latch enables, bit n = bank n
//   BANKSEL   in   readback bank select (0..6, 7 reads 0)
//   ERRCLR    in   clears SEQERR / MHERR (a same-cycle new error wins)
//   CHGCLR    in   clears CHG (only with change detection built)
//   RDATA     out  bank[BANKSEL], combinational
//   BANKVLD   out  bank n captured at least once since reset
//   FRMDONE   out  one-cycle pulse after a complete in-order frame 0..6
//   FRMCNT    out  count of FRMDONE pulses, wraps
//   SEQERR    out  sticky, bank captured out of order
//   MHERR     out  sticky, illegal multi-hot PUPLE
//   STALE     out  watchdog saturated
//   CHG       out  sticky, bank n value changed on recapture
//
// Build option: define IERL78PUCAP7_CHGDET_EN to build the bank change
// detector; otherwise CHG is tied low and CHGCLR is ignored.
// ---------------------------------------------------------------------------
module ierl78pucap7 #(
    parameter int TMO_W = 16
) (
    input  logic        CLK60MHZ,
    input  logic        CPURSOUT,
    input  logic [29:0] PPUP,
    input  logic [6:0]  PUPLE,
    input  logic [2:0]  BANKSEL,
    input  logic        ERRCLR,
    input  logic        CHGCLR,
    output logic [29:0] RDATA,
    output logic [6:0]  BANKVLD,
    output logic        FRMDONE,
    output logic [7:0]  FRMCNT,
    output logic        SEQERR,
    output logic        MHERR,
    output logic        STALE,
    output logic [6:0]  CHG
);

    localparam int NB = 7;
    localparam int DW = 30;

    // Synchroniser stages. Data and enables take the same number of stages
    // so the captured word is the one that travelled alongside the enable.
    logic [DW-1:0]   ppup_s1_q, ppup_s_q;
    logic [NB-1:0]   ple_s1_q, ple_s_q, ple_d_q;

    logic [DW-1:0]   bank_q [NB];
    logic [DW-1:0]   bank_d [NB];
    logic [NB-1:0]   bankvld_q, bankvld_d;
    logic [2:0]      exp_q, exp_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frmdone_q, frmdone_d;
    logic [7:0]      frmcnt_q, frmcnt_d;
    logic            seqerr_q, seqerr_d;
    logic            mherr_q, mherr_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;

    // Enable decode
    logic [NB-1:0]   rise;
    logic            onehot;
    logic            all_high;
    logic            capture;
    logic            mh_set;
    logic            seq_set;
    logic [2:0]      cap_idx;
    logic [2:0]      next_idx;

    always_comb begin
        rise     = ple_s_q & ~ple_d_q;
        onehot   = (ple_s_q != '0) && ((ple_s_q & (ple_s_q - 7'd1)) == '0);
        all_high = (ple_s_q == 7'h7F);
        // Only the edge of the single active enable triggers a capture, so a
        // held enable is latched exactly once.
        capture  = onehot && ((rise & ple_s_q) != '0);
        // All-high means the transmitter is in reset: not an error.
        mh_set   = !onehot && !all_high && (rise != '0);
        cap_idx  = 3'd0;
        for (int i = 0; i < NB; i++) begin
            if (ple_s_q[i]) begin
                cap_idx = 3'(i);
            end
        end
        next_idx = (cap_idx == 3'd6) ? 3'd0 : cap_idx + 3'd1;
    end

    // Bank storage, sequencer, frame counter, watchdog
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            bank_d[i] = bank_q[i];
        end
        bankvld_d  = bankvld_q;
        exp_d      = exp_q;
        frame_ok_d = frame_ok_q;
        frmdone_d  = 1'b0;
        frmcnt_d   = frmcnt_q;
        seq_set    = 1'b0;

        if (capture) begin
            for (int i = 0; i < NB; i++) begin
                if (ple_s_q[i]) begin
                    bank_d[i]    = ppup_s_q;
                    bankvld_d[i] = 1'b1;
                end
            end
            exp_d = next_idx;
            if (cap_idx != exp_q) begin
                seq_set    = 1'b1;
                frame_ok_d = 1'b0;
            end
            // Bank 0 opens a new frame even after an ordering error.
            if (cap_idx == 3'd0) begin
                frame_ok_d = 1'b1;
            end
            if ((cap_idx == 3'd6) && (exp_q == 3'd6) && frame_ok_q) begin
                frmdone_d = 1'b1;
                frmcnt_d  = frmcnt_q + 8'd1;
            end
        end else if (all_high) begin
            exp_d      = 3'd0;
            frame_ok_d = 1'b0;
        end

        seqerr_d = (seqerr_q && !ERRCLR) || seq_set;
        mherr_d  = (mherr_q && !ERRCLR) || mh_set;

        if (capture) begin
            wdog_d = '0;
        end else if (wdog_q == '1) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK60MHZ or posedge CPURSOUT) begin
        if (CPURSOUT) begin
            ppup_s1_q  <= '0;
            ppup_s_q   <= '0;
            ple_s1_q   <= '0;
            ple_s_q    <= '0;
            ple_d_q    <= '0;
            for (int i = 0; i < NB; i++) begin
                bank_q[i] <= '0;
            end
            bankvld_q  <= '0;
            exp_q      <= '0;
            frame_ok_q <= 1'b0;
            frmdone_q  <= 1'b0;
            frmcnt_q   <= '0;
            seqerr_q   <= 1'b0;
            mherr_q    <= 1'b0;
            wdog_q     <= '0;
        end else begin
            ppup_s1_q  <= PPUP;
            ppup_s_q   <= ppup_s1_q;
            ple_s1_q   <= PUPLE;
            ple_s_q    <= ple_s1_q;
            ple_d_q    <= ple_s_q;
            for (int i = 0; i < NB; i++) begin
                bank_q[i] <= bank_d[i];
            end
            bankvld_q  <= bankvld_d;
            exp_q      <= exp_d;
            frame_ok_q <= frame_ok_d;
            frmdone_q  <= frmdone_d;
            frmcnt_q   <= frmcnt_d;
            seqerr_q   <= seqerr_d;
            mherr_q    <= mherr_d;
            wdog_q     <= wdog_d;
        end
    end

`ifdef IERL78PUCAP7_CHGDET_EN
    logic [NB-1:0] chg_q, chg_d;

    // Clear first, then set, so a change seen in the clear cycle survives.
    always_comb begin
        chg_d = chg_q & ~{NB{CHGCLR}};
        if (capture) begin
            for (int i = 0; i < NB; i++) begin
                if (ple_s_q[i] && bankvld_q[i] && (ppup_s_q != bank_q[i])) begin
                    chg_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK60MHZ or posedge CPURSOUT) begin
        if (CPURSOUT) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign CHG = chg_q;
`else
    logic unused_chgclr;
    assign unused_chgclr = CHGCLR;
    assign CHG = '0;
`endif

    // Readback mux; select 7 has no bank behind it and reads 0.
    always_comb begin
        RDATA = '0;
        for (int i = 0; i < NB; i++) begin
            if (BANKSEL == 3'(i)) begin
                RDATA = bank_q[i];
            end
        end
    end

    assign BANKVLD = bankvld_q;
    assign FRMDONE = frmdone_q;
    assign FRMCNT  = frmcnt_q;
    assign SEQERR  = seqerr_q;
    assign MHERR   = mherr_q;
    assign STALE   = (wdog_q == '1);

endmodule

// File: tb/tb_ierl78pucap7.sv
`timescale 1ns/1ps
module tb_ierl78pucap7;

    localparam int TMO_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PPUP;
    logic [6:0]  PUPLE;
    logic [2:0]  BANKSEL;
    logic        ERRCLR;
    logic        CHGCLR;
    logic [29:0] RDATA;
    logic [6:0]  BANKVLD;
    logic        FRMDONE;
    logic [7:0]  FRMCNT;
    logic        SEQERR;
    logic        MHERR;
    logic        STALE;
    logic [6:0]  CHG;

    always #5 clk = ~clk;

    ierl78pucap7 #(.TMO_W(TMO_W)) dut (
        .CLK60MHZ (clk),
        .CPURSOUT (rst),
        .PPUP     (PPUP),
        .PUPLE    (PUPLE),
        .BANKSEL  (BANKSEL),
        .ERRCLR   (ERRCLR),
        .CHGCLR   (CHGCLR),
        .RDATA    (RDATA),
        .BANKVLD  (BANKVLD),
        .FRMDONE  (FRMDONE),
        .FRMCNT   (FRMCNT),
        .SEQERR   (SEQERR),
        .MHERR    (MHERR),
        .STALE    (STALE),
        .CHG      (CHG)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference contents of the banks
    logic [29:0] m_bank [7];
    logic [6:0]  m_vld;
    logic [6:0]  m_chg;

    // FRMDONE pulse monitor
    int   frm_pulses = 0;
    int   frm_long   = 0;
    logic frm_prev   = 1'b0;
    always @(negedge clk) begin
        if (FRMDONE === 1'b1) begin
            if (frm_prev) frm_long++;
            else          frm_pulses++;
        end
        frm_prev = (FRMDONE === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_bank[i] = '0;
        m_vld = '0;
        m_chg = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; PUPLE = '0; PPUP = '0; ERRCLR = 1'b0; CHGCLR = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One bank transfer: data set up 2 clocks ahead, enable high 3 clocks.
    task automatic send(input int n, input logic [29:0] d);
        PPUP = d;
        repeat (2) @(negedge clk);
        PUPLE = 7'(1 << n);
        repeat (3) @(negedge clk);
        PUPLE = '0;
        repeat (2) @(negedge clk);
`ifdef IERL78PUCAP7_CHGDET_EN
        if (m_vld[n] && (m_bank[n] != d)) m_chg[n] = 1'b1;
`endif
        m_bank[n] = d;
        m_vld[n]  = 1'b1;
    endtask

    task automatic pulse_errclr();
        ERRCLR = 1'b1;
        @(negedge clk);
        ERRCLR = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [29:0] expv;
        rst = 1'b1; PUPLE = '0; PPUP = '0; BANKSEL = '0; ERRCLR = 1'b0; CHGCLR = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            BANKSEL = 3'(b);
            #1;
            expv = '0;
            n_vec++;
            if (RDATA !== expv) begin
                n_fail++;
                $display("FAIL reset_rdata[%0d]: got %h expected %h", b, RDATA, expv);
            end
        end
        n_vec++;
        if ({BANKVLD, FRMDONE, FRMCNT, SEQERR, MHERR, STALE, CHG} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got vld=%h done=%b cnt=%0d seq=%b mh=%b stale=%b chg=%h expected all 0",
                     BANKVLD, FRMDONE, FRMCNT, SEQERR, MHERR, STALE, CHG);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_in_order();
        int base;
        logic [29:0] expv;
        base = frm_pulses;
        for (int n = 0; n < 7; n++) send(n, 30'h0111_1111 * 30'(n));
        for (int b = 0; b < 8; b++) begin
            BANKSEL = 3'(b);
            #1;
            expv = (b < 7) ? 30'h0111_1111 * 30'(b) : 30'd0;
            n_vec++;
            if (RDATA !== expv) begin
                n_fail++;
                $display("FAIL inorder_rdata[%0d]: got %h expected %h", b, RDATA, expv);
            end
        end
        n_vec++;
        if (BANKVLD !== 7'h7F) begin
            n_fail++; $display("FAIL inorder_bankvld: got %h expected 7f", BANKVLD);
        end
        n_vec++;
        if (frm_pulses - base !== 1 || frm_long !== 0) begin
            n_fail++; $display("FAIL inorder_frmdone: got %0d pulses (%0d long) expected 1 (0)", frm_pulses - base, frm_long);
        end
        n_vec++;
        if (FRMCNT !== 8'd1) begin
            n_fail++; $display("FAIL inorder_frmcnt: got %0d expected 1", FRMCNT);
        end
        n_vec++;
        if (SEQERR !== 1'b0) begin
            n_fail++; $display("FAIL inorder_seqerr: got %b expected 0", SEQERR);
        end
        $display("test_in_order done");
    endtask

    task automatic test_seqerr();
        int base;
        base = frm_pulses;
        send(0, 30'h2000_0000); send(1, 30'h2000_0001); send(3, 30'h2000_0003);
        n_vec++;
        if (SEQERR !== 1'b1) begin
            n_fail++; $display("FAIL seq_skip: got SEQERR=%b expected 1", SEQERR);
        end
        for (int n = 4; n < 7; n++) send(n, 30'h2000_0000 | 30'(n));
        n_vec++;
        if (frm_pulses !== base || FRMCNT !== 8'd1) begin
            n_fail++; $display("FAIL seq_nodone: got %0d pulses cnt=%0d expected 0 pulses cnt=1", frm_pulses - base, FRMCNT);
        end
        pulse_errclr();
        n_vec++;
        if (SEQERR !== 1'b0) begin
            n_fail++; $display("FAIL seq_errclr: got SEQERR=%b expected 0", SEQERR);
        end
        for (int n = 0; n < 7; n++) send(n, 30'h2000_0010 | 30'(n));
        n_vec++;
        if (frm_pulses - base !== 1 || FRMCNT !== 8'd2 || SEQERR !== 1'b0) begin
            n_fail++; $display("FAIL seq_refrm: got %0d pulses cnt=%0d seq=%b expected 1 pulse cnt=2 seq=0",
                               frm_pulses - base, FRMCNT, SEQERR);
        end
        $display("test_seqerr done");
    endtask

    task automatic test_multihot();
        send(0, 30'h3000_0000); send(1, 30'h3000_0001);
        PPUP = 30'h3FFF_FFFF;
        repeat (2) @(negedge clk);
        PUPLE = 7'h05;
        repeat (3) @(negedge clk);
        PUPLE = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (MHERR !== 1'b1) begin
            n_fail++; $display("FAIL mh_set: got MHERR=%b expected 1", MHERR);
        end
        for (int b = 0; b < 7; b++) begin
            BANKSEL = 3'(b);
            #1;
            n_vec++;
            if (RDATA !== m_bank[b]) begin
                n_fail++; $display("FAIL mh_bank[%0d]: got %h expected %h", b, RDATA, m_bank[b]);
            end
        end
        PUPLE = 7'h7F;
        repeat (3) @(negedge clk);
        PUPLE = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (MHERR !== 1'b1 || SEQERR !== 1'b0) begin
            n_fail++; $display("FAIL mh_allhigh: got mh=%b seq=%b expected mh=1 seq=0", MHERR, SEQERR);
        end
        BANKSEL = 3'd0;
        #1;
        n_vec++;
        if (RDATA !== m_bank[0]) begin
            n_fail++; $display("FAIL mh_allhigh_nocap: got %h expected %h", RDATA, m_bank[0]);
        end
        pulse_errclr();
        n_vec++;
        if (MHERR !== 1'b0) begin
            n_fail++; $display("FAIL mh_errclr: got MHERR=%b expected 0", MHERR);
        end
        // Pointer was sent back to 0 by the all-high word, so bank 0 is in order.
        send(0, 30'h3000_0100);
        n_vec++;
        if (SEQERR !== 1'b0) begin
            n_fail++; $display("FAIL mh_expreset: got SEQERR=%b expected 0", SEQERR);
        end
        $display("test_multihot done");
    endtask

    task automatic test_stale();
        logic [29:0] old;
        logic [29:0] d;
        BANKSEL = 3'd1;
        old = m_bank[1];
        d = 30'h0ABC_DEF0;
        PPUP = d;
        repeat (2) @(negedge clk);
        PUPLE = 7'h02;
        repeat (2) @(negedge clk);
        n_vec++;
        if (RDATA !== old) begin
            n_fail++; $display("FAIL latency_early: got %h expected %h", RDATA, old);
        end
        @(negedge clk);
        n_vec++;
        if (RDATA !== d) begin
            n_fail++; $display("FAIL latency_3: got %h expected %h", RDATA, d);
        end
`ifdef IERL78PUCAP7_CHGDET_EN
        if (m_vld[1] && (m_bank[1] != d)) m_chg[1] = 1'b1;
`endif
        m_bank[1] = d; m_vld[1] = 1'b1;
        PUPLE = '0;
        repeat (14) @(negedge clk);
        n_vec++;
        if (STALE !== 1'b0) begin
            n_fail++; $display("FAIL stale_14: got STALE=%b expected 0", STALE);
        end
        @(negedge clk);
        n_vec++;
        if (STALE !== 1'b1) begin
            n_fail++; $display("FAIL stale_15: got STALE=%b expected 1", STALE);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (STALE !== 1'b1) begin
            n_fail++; $display("FAIL stale_hold: got STALE=%b expected 1", STALE);
        end
        send(2, 30'h0000_0F0F);
        n_vec++;
        if (STALE !== 1'b0) begin
            n_fail++; $display("FAIL stale_clear: got STALE=%b expected 0", STALE);
        end
        $display("test_stale done");
    endtask

    task automatic test_chg();
        logic [6:0] want;
        do_reset();
        send(2, 30'h1);
        n_vec++;
        if (CHG !== 7'h00) begin
            n_fail++; $display("FAIL chg_first: got %h expected 00", CHG);
        end
        send(2, 30'h1);
        n_vec++;
        if (CHG !== 7'h00) begin
            n_fail++; $display("FAIL chg_same: got %h expected 00", CHG);
        end
        send(2, 30'h2);
`ifdef IERL78PUCAP7_CHGDET_EN
        want = 7'h04;
`else
        want = 7'h00;
`endif
        n_vec++;
        if (CHG !== want || m_chg !== want) begin
            n_fail++; $display("FAIL chg_diff: got %h expected %h", CHG, want);
        end
        CHGCLR = 1'b1;
        @(negedge clk);
        CHGCLR = 1'b0;
        @(negedge clk);
        m_chg = '0;
        n_vec++;
        if (CHG !== 7'h00) begin
            n_fail++; $display("FAIL chg_clr: got %h expected 00", CHG);
        end
        $display("test_chg done");
    endtask

    task automatic test_reset_mid();
        int base;
        for (int n = 0; n < 7; n++) send(n, 30'h1500_0000 | 30'(n));
        n_vec++;
        if (FRMCNT !== 8'd1) begin
            n_fail++; $display("FAIL mid_prefrm: got FRMCNT=%0d expected 1", FRMCNT);
        end
        for (int n = 0; n < 4; n++) send(n, 30'h1600_0000 | 30'(n));
        @(negedge clk);
        #2 rst = 1'b1;
        for (int b = 0; b < 7; b++) begin
            BANKSEL = 3'(b);
            #1;
            n_vec++;
            if (RDATA !== 30'd0) begin
                n_fail++; $display("FAIL mid_rdata[%0d]: got %h expected 0", b, RDATA);
            end
        end
        n_vec++;
        if ({BANKVLD, FRMDONE, FRMCNT, SEQERR, MHERR, STALE, CHG} !== 26'd0) begin
            n_fail++;
            $display("FAIL mid_flags: got vld=%h done=%b cnt=%0d seq=%b mh=%b stale=%b chg=%h expected all 0",
                     BANKVLD, FRMDONE, FRMCNT, SEQERR, MHERR, STALE, CHG);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        base = frm_pulses;
        for (int n = 0; n < 7; n++) send(n, 30'h1700_0000 | 30'(n));
        n_vec++;
        if (FRMCNT !== 8'd1 || frm_pulses - base !== 1 || SEQERR !== 1'b0) begin
            n_fail++; $display("FAIL mid_newfrm: got cnt=%0d pulses=%0d seq=%b expected cnt=1 pulses=1 seq=0",
                               FRMCNT, frm_pulses - base, SEQERR);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_seqerr();
        test_multihot();
        test_stale();
        test_chg();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ierl78pucap7.md
# ierl78pucap7

Pull-up bus capture unit: the receiving end of the RL78 IECUBE 7-bank pull-up distribution bus. It sits on the IO-board side. It samples the time-multiplexed 30-bit PPUP bus and the seven PUPLE latch enables. It rebuilds the seven 30-bit pull-up banks and checks bank ordering, multi-hot enables and bus staleness. Banks can be read back through a select port for the debug/monitor path.

## Interface
Parameters:
- TMO_W, 16: width of the stale watchdog counter. STALE asserts after 2^TMO_W−1 cycles with no capture.

Ports (one clock; reset is asynchronous and active-high):
- CLK60MHZ  in  1  system clock, all logic on posedge
- CPURSOUT  in  1  asynchronous active-high reset
- PPUP      in  30  pull-up data bus; bit 29 = PPUP0 … bit 8 = PPUP21, bit 7 = PPUP24 … bit 0 = PPUP31
- PUPLE     in  7  latch enables, bit n = PUPLE<n>, high pulse = bank n valid
- BANKSEL   in  3  readback bank select, 0–6
- ERRCLR    in  1  clears SEQERR/MHERR
- CHGCLR    in  1  clears CHG (only with CHGDET)
- RDATA     out 30  captured bank[BANKSEL], combinational; 0 for BANKSEL=7
- BANKVLD   out 7  bank n captured at least once since reset
- FRMDONE   out 1  one-cycle pulse, complete in-order frame 0..6 captured
- FRMCNT    out 8  FRMDONE count, wraps 255→0
- SEQERR    out 1  sticky, out-of-order bank
- MHERR     out 1  sticky, illegal multi-hot PUPLE
- STALE     out 1  watchdog saturated
- CHG       out 7  sticky, bank n value changed

## Operation
- Input sync: PPUP and PUPLE each pass through an identical 2-FF synchronizer, so data stays aligned with enables. A third PUPLE stage (ple_d) feeds edge detection.
- Rise vector: rise = ple_s & ~ple_d.
- Capture: fires when ple_s is one-hot and rise for that bit is set. bank[n] ← PPUP_s. BANKVLD[n] ← 1.
- All-seven-high (ple_s == 7'h7F), i.e. transmitter in reset:
  - no capture and no error
  - expected pointer exp ← 0
  - frame-ok flag cleared
- Any other multi-hot with a rise present: MHERR ← 1, no capture.
- Sequencer. exp[2:0] resets to 0. On capture of bank n:
  - n == exp: exp ← (n==6 ? 0 : n+1).
  - otherwise: SEQERR ← 1, exp ← (n==6 ? 0 : n+1), frame-ok ← 0.
  - n == 0: frame-ok ← 1, overriding any clear from the same capture.
  - n == 6 with frame-ok=1 and n==exp: FRMDONE pulses next cycle and FRMCNT increments.
- Watchdog: TMO_W-bit counter. Clears on every capture, otherwise increments and saturates at all-ones. STALE = (counter == all-ones).
- ERRCLR clears SEQERR and MHERR. If a new error is detected in the same cycle, set wins.
- Reset mid-operation clears everything immediately and asynchronously: banks, exp, flags, counters.

## Timing
- Reset values: RDATA 0 (all banks 0), BANKVLD 0, FRMDONE 0, FRMCNT 0, SEQERR 0, MHERR 0, STALE 0, CHG 0.
- Latency from PUPLE rising at the pin to the bank update (visible on RDATA): 3 posedges (2 sync + 1 capture).
- FRMDONE asserts 1 cycle after the bank-6 capture and lasts exactly 1 cycle. FRMCNT updates on the same edge FRMDONE rises.
- Minimum PUPLE high width: 2 clocks, for synchronizer safety. PPUP must be stable from 2 clocks before the PUPLE rise until 1 clock after it.
- An enable held high is captured only once (edge-triggered).
- STALE rises on cycle 2^TMO_W−1 after the last capture and falls the cycle after the next capture.

## Configuration
- IERL78PUCAP7_CHGDET_EN defined:
  - On each capture of bank n with BANKVLD[n]=1 already set and PPUP_s ≠ bank[n], CHG[n] ← 1.
  - The first capture of a bank never sets CHG.
  - CHGCLR clears all CHG bits; a same-cycle set wins.
- Not defined: CHG is tied to 0, CHGCLR is ignored, and no compare logic is built.

## Test plan
- Reset, then drive PUPLE pulses 0..6 in order with PPUP = 30'h0000_0000+n·30'h0111_1111. Required: RDATA for each BANKSEL matches, BANKVLD=7'h7F, one FRMDONE pulse, FRMCNT=1, SEQERR=0.
- Drive order 0,1,3 (bank 2 skipped). Required: SEQERR=1 after the bank-3 capture, and no FRMDONE after bank 6. Assert ERRCLR: SEQERR=0. Repeat the full in-order frame: FRMDONE fires.
- Drive PUPLE=7'h05 (two banks high). Required: MHERR=1, no bank changed. Drive PUPLE=7'h7F: MHERR unchanged, exp reset to 0, no capture.
- Hold PUPLE=0 for 2^TMO_W−1 cycles (TMO_W=4 → 15 cycles). Required: STALE=1 on cycle 15. A single capture then clears STALE.
- With CHGDET_EN: capture bank 2 = 30'h1, then 30'h1 again (CHG=0), then 30'h2. Required: CHG=7'h04. CHGCLR → CHG=0. Without the macro, CHG stays 0.
- Assert CPURSOUT mid-frame after bank 3. Required: all outputs return to reset values asynchronously. The next frame starting at bank 0 completes with FRMCNT=1.
